// File: rtl/dcache_block_fill.sv
// dcache_block_fill: direct-mapped write-through no-write-allocate data cache.
// A load miss stalls, then the whole line is refilled from one block read.
module dcache_block_fill #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 30,
  parameter int BLOCK_SIZE    = 3,
  parameter int INDEX_BITS    = 4,
  parameter int MISS_LATENCY  = 2
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [ADDRESS_WIDTH-1:0]              cpu_address,
  input  logic                                  cpu_read,
  input  logic                                  cpu_write,
  input  logic [DATA_WIDTH-1:0]                 cpu_write_data,
  output logic [DATA_WIDTH-1:0]                 cpu_read_data,
  output logic                                  stall,
  output logic [ADDRESS_WIDTH-1:0]              mem_address,
  output logic [DATA_WIDTH-1:0]                 mem_write_data,
  output logic                                  mem_write_enable,
  input  logic [(2**BLOCK_SIZE)*DATA_WIDTH-1:0] mem_read_data,
  output logic [31:0]                           hit_count,
  output logic [31:0]                           miss_count
);
  localparam int S     = 2**BLOCK_SIZE;
  localparam int LINES = 2**INDEX_BITS;
  localparam int TAG_W = ADDRESS_WIDTH - BLOCK_SIZE - INDEX_BITS;
  typedef enum logic {IDLE, FILL} state_t;
  state_t                   r_state, w_next;
  logic [3:0]               r_cnt;
  logic [ADDRESS_WIDTH-1:0] r_base;
  logic [LINES-1:0]         r_valid;
  logic [TAG_W-1:0]         r_tag [LINES];
  logic [DATA_WIDTH-1:0]    r_data [LINES][S];
  logic [BLOCK_SIZE-1:0]    w_offset;
  logic [INDEX_BITS-1:0]    w_index, w_fill_index;
  logic [TAG_W-1:0]         w_tag, w_fill_tag;
  logic                     w_hit, w_load, w_store, w_fill_done;
  assign w_offset     = cpu_address[BLOCK_SIZE-1:0];
  assign w_index      = cpu_address[BLOCK_SIZE +: INDEX_BITS];
  assign w_tag        = cpu_address[ADDRESS_WIDTH-1 -: TAG_W];
  assign w_fill_index = r_base[BLOCK_SIZE +: INDEX_BITS];
  assign w_fill_tag   = r_base[ADDRESS_WIDTH-1 -: TAG_W];
  assign w_hit        = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_store      = (r_state == IDLE) && cpu_write;
  assign w_load       = (r_state == IDLE) && cpu_read && !cpu_write;
  assign w_fill_done  = (r_state == FILL) && (r_cnt == 4'(MISS_LATENCY - 1));
  // Outputs are gated by rst_n so they drop to 0 the moment reset asserts.
  always_comb begin
    w_next           = r_state;
    stall            = 1'b0;
    mem_address      = '0;
    mem_write_data   = '0;
    mem_write_enable = 1'b0;
    cpu_read_data    = '0;
    if (rst_n) begin
      if (r_state == FILL) begin
        stall       = 1'b1;
        mem_address = r_base;
        w_next      = w_fill_done ? IDLE : FILL;
      end else if (cpu_write) begin
        mem_write_enable = 1'b1;
        mem_address      = cpu_address;
        mem_write_data   = cpu_write_data;
      end else if (cpu_read) begin
        cpu_read_data = w_hit ? r_data[w_index][w_offset] : '0;
        stall         = !w_hit;
        mem_address   = w_hit ? '0 : {cpu_address[ADDRESS_WIDTH-1:BLOCK_SIZE], BLOCK_SIZE'(0)};
        w_next        = w_hit ? IDLE : FILL;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_base     <= '0;
      r_valid    <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (r_state == FILL) ? r_cnt + 4'd1 : '0;
      if (w_load && !w_hit) r_base <= {cpu_address[ADDRESS_WIDTH-1:BLOCK_SIZE], BLOCK_SIZE'(0)};
      if (w_fill_done) r_valid[w_fill_index] <= 1'b1;
      if (w_load && w_hit && hit_count != '1) hit_count <= hit_count + 32'd1;
      if (w_load && !w_hit && miss_count != '1) miss_count <= miss_count + 32'd1;
    end
  end
  // Tags and data need no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (w_fill_done) begin
      r_tag[w_fill_index] <= w_fill_tag;
      for (int i = 0; i < S; i++) r_data[w_fill_index][i] <= mem_read_data[i*DATA_WIDTH +: DATA_WIDTH];
    end else if (w_store && w_hit) begin
      r_data[w_index][w_offset] <= cpu_write_data;
    end
  end
endmodule

// File: doc/dcache_block_fill.md
Name: dcache_block_fill

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the CPU load/store stage and the block-read data memory.
- Data memory returns a full block of 2**BLOCK_SIZE words per access; this block consumes that block on a miss, refills one line, then serves word hits with zero stall.
- Word-addressed throughout. No byte enables.

Parameters:
- DATA_WIDTH, 32, word width.
- ADDRESS_WIDTH, 30, word address width.
- BLOCK_SIZE, 3, log2 of words per line (S = 2**BLOCK_SIZE = 8).
- INDEX_BITS, 4, log2 of line count (16 lines).
- MISS_LATENCY, 2, cycles spent in FILL before the memory block is captured (range 1..15).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cpu_address  in  ADDRESS_WIDTH  word address of request.
- cpu_read  in  1  load request.
- cpu_write  in  1  store request.
- cpu_write_data  in  DATA_WIDTH  store data.
- cpu_read_data  out  DATA_WIDTH  load result, valid when cpu_read=1 and stall=0.
- stall  out  1  CPU must hold its request unchanged while high.
- mem_address  out  ADDRESS_WIDTH  address to data memory.
- mem_write_data  out  DATA_WIDTH  store data to data memory.
- mem_write_enable  out  1  data memory write strobe.
- mem_read_data  in  S*DATA_WIDTH  block from data memory, packed; word i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- hit_count  out  32  load hits since reset.
- miss_count  out  32  load misses since reset.

Behaviour:
- Address split:
  - offset = cpu_address[BLOCK_SIZE-1:0].
  - index = next INDEX_BITS bits.
  - tag = remaining upper bits.
- Storage per line: valid bit, tag, S data words.
- Reset (async, rst_n=0):
  - All valid bits cleared, state=IDLE, fill counter=0.
  - hit_count=0, miss_count=0.
  - All outputs 0 (stall=0, mem_write_enable=0, cpu_read_data=0, mem_address=0).
  - Reset during FILL abandons the fill; the line stays invalid.
- State IDLE:
  - hit = valid[index] && tag match.
  - Store (cpu_write=1) has priority over load; cpu_read is ignored when both are high.
  - Store:
    - Same cycle: mem_write_enable=1, mem_address=cpu_address, mem_write_data=cpu_write_data, stall=0.
    - If hit, the cached word at index/offset is updated on the same edge. If miss, no allocation.
    - Counters unchanged.
  - Load hit: cpu_read_data = cached word, combinational, stall=0, hit_count+1 on the edge.
  - Load miss:
    - stall=1 combinationally in the same cycle; mem_address = cpu_address with offset bits zeroed.
    - miss_count+1 on the edge, next state FILL, counter loaded with 0.
  - No request: all mem outputs 0, stall=0, cpu_read_data=0.
- State FILL:
  - stall=1, mem_address held at block base, mem_write_enable=0.
  - CPU inputs ignored; CPU holds its request.
  - Counter increments each cycle. On the cycle counter == MISS_LATENCY-1:
    - capture all S words of mem_read_data into the line;
    - set valid, write tag, next state IDLE.
  - The held load re-evaluates in IDLE, hits, and increments hit_count. Miss-to-data latency = MISS_LATENCY+1 cycles after the miss cycle.
  - cpu_read_data=0 while stall=1.
- Counters: saturate at 32'hFFFF_FFFF, no wrap.
- Index wrap: addresses differing only in tag map to the same line; a refill overwrites the line (conflict eviction, no writeback needed because the cache is write-through).

Test Plan:
- Reset, then load addr 0x40 (mem block base 0x40 = words 0x100..0x107) -> stall=1 for 3 cycles, mem_address=0x40; then cpu_read_data=0x100, stall=0; miss_count=1, hit_count=1.
- After the above, load 0x47 -> same-cycle cpu_read_data=0x107, stall=0, hit_count=2, no mem activity.
- Store 0xDEAD to 0x43 (hit) -> mem_write_enable=1, mem_address=0x43 for one cycle; next load 0x43 returns 0xDEAD with no stall.
- Store to 0x200 (miss, line invalid) -> mem write issued, stall=0; subsequent load 0x200 misses (miss_count+1), confirming no-write-allocate.
- Conflict: load 0x40, then load 0x40+(16*8)=0xC0 (same index, new tag) -> second load refills; reload 0x40 misses again.
- Assert rst_n low mid-FILL -> stall and all outputs 0 immediately; after release, load 0x40 misses again with miss_count=1.
